// File: rtl/maze_pkg.sv
// Shared definitions for the maze path finder.
//   maze_state_e : controller state encoding
//   DIR_*        : neighbour encoding, also the search priority order (lowest first)
//   coord_w()    : width needed to hold a row or column index of an N x N maze
package maze_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_INIT   = 3'd2,
        ST_SEARCH = 3'd3,
        ST_OUTPUT = 3'd4
    } maze_state_e;

    localparam logic [1:0] DIR_DOWN = 2'd0;  // row + 1
    localparam logic [1:0] DIR_CM1  = 2'd1;  // col - 1
    localparam logic [1:0] DIR_UP   = 2'd2;  // row - 1 (four-direction mode only)
    localparam logic [1:0] DIR_CP1  = 2'd3;  // col + 1 (four-direction mode only)

    function automatic int coord_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maze_dfs_stack.sv
// LIFO of {row,col} cells for the depth-first search.
//   clear     : empty the stack; a push in the same cycle lands at entry 0
//   push/pop  : at most one per cycle; push wins
//   push_data : {row,col} to push
//   top_data  : entry sp-1 (undefined when empty)
//   rd_idx    : index for the streaming read port, rd_data = entry rd_idx
//   sp        : number of entries held, empty = (sp == 0)
module maze_dfs_stack
    import maze_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      push,
    input  logic                      pop,
    input  logic [2*CW-1:0]           push_data,
    input  logic [$clog2(N*N)-1:0]    rd_idx,
    output logic [2*CW-1:0]           top_data,
    output logic [2*CW-1:0]           rd_data,
    output logic [$clog2(N*N+1)-1:0]  sp,
    output logic                      empty
);
    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2(DEPTH + 1);

    logic [2*CW-1:0] mem_q [DEPTH];
    logic [PW-1:0]   sp_q, sp_d, base;

    always_comb begin
        base = clear ? '0 : sp_q;
        sp_d = base;
        if (push)
            sp_d = base + 1'b1;
        else if (pop && base != '0)
            sp_d = base - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    // Storage needs no reset: only entries below sp are ever read meaningfully.
    always_ff @(posedge clk) begin
        if (push) mem_q[AW'(base)] <= push_data;
    end

    assign top_data = mem_q[AW'(sp_q - 1'b1)];
    assign rd_data  = mem_q[rd_idx];
    assign sp       = sp_q;
    assign empty    = (sp_q == '0);

endmodule

// File: rtl/maze_path_finder.sv
// Rat-in-a-maze solver: loads an N x N maze row by row, depth-first searches
// from (0,N-1) to (N-1,0) and streams the path, or pulses no_path.
//   in_valid/maze         : row beat, bit c = cell (row,c) open
//   busy                  : operation in progress (not IDLE)
//   out_valid/out_row/out_col/out_last : path stream, start cell first, goal last
//   no_path               : one-cycle pulse when no route exists
//
// state  | meaning
// IDLE   | waiting for row 0
// LOAD   | storing rows 1..N-1, in_valid=0 stalls
// INIT   | check start/goal open, seed the stack with the start cell
// SEARCH | one push (first free neighbour) or one pop per cycle
// OUTPUT | stream stack entries 0..sp-1
module maze_path_finder
    import maze_pkg::*;
#(
    parameter int N        = 8,
    parameter int FOUR_DIR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [N-1:0]          maze,
    output logic                  busy,
    output logic                  out_valid,
    output logic [coord_w(N)-1:0] out_row,
    output logic [coord_w(N)-1:0] out_col,
    output logic                  out_last,
    output logic                  no_path
);
    localparam int CW = coord_w(N);
    localparam int AW = $clog2(N * N);
    localparam int PW = $clog2(N * N + 1);
    localparam logic [CW:0] CN = (CW + 1)'(N);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_LOAD   = 3'(ST_LOAD);
    localparam logic [2:0] S_INIT   = 3'(ST_INIT);
    localparam logic [2:0] S_SEARCH = 3'(ST_SEARCH);
    localparam logic [2:0] S_OUTPUT = 3'(ST_OUTPUT);

    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       row_cnt_q, row_cnt_d;
    logic [N-1:0][N-1:0] maze_q, maze_d;
    logic [N-1:0][N-1:0] vis_q, vis_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                no_path_q, no_path_d;
    logic [CW-1:0]       out_row_q, out_row_d, out_col_q, out_col_d;

    logic                stk_clear, stk_push, stk_pop, stk_empty;
    logic [2*CW-1:0]     stk_push_data, stk_top, stk_rd;
    logic [PW-1:0]       stk_sp;
    logic [CW-1:0]       top_row, top_col, sel_r, sel_c;
    logic                sel_ok;
    logic [CW:0]         cand_r [4];
    logic [CW:0]         cand_c [4];
    logic [3:0]          cand_ok;

    maze_dfs_stack #(.N(N), .CW(CW)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (stk_push_data),
        .rd_idx    (idx_q),
        .top_data  (stk_top),
        .rd_data   (stk_rd),
        .sp        (stk_sp),
        .empty     (stk_empty)
    );

    assign {top_row, top_col} = stk_top;

    // Neighbours are formed one bit wider than a coordinate so that row N and
    // col -1 (all ones) both fail the unsigned "< N" bound instead of wrapping.
    always_comb begin
        cand_r[DIR_DOWN] = {1'b0, top_row} + 1'b1;
        cand_c[DIR_DOWN] = {1'b0, top_col};
        cand_r[DIR_CM1]  = {1'b0, top_row};
        cand_c[DIR_CM1]  = {1'b0, top_col} - 1'b1;
        cand_r[DIR_UP]   = {1'b0, top_row} - 1'b1;
        cand_c[DIR_UP]   = {1'b0, top_col};
        cand_r[DIR_CP1]  = {1'b0, top_row};
        cand_c[DIR_CP1]  = {1'b0, top_col} + 1'b1;
        cand_ok = '0;
        for (int d = 0; d < 4; d++) begin
            cand_ok[2'(d)] = (cand_r[2'(d)] < CN) && (cand_c[2'(d)] < CN)
                && (d < 2 || FOUR_DIR != 0)
                && maze_q[cand_r[2'(d)][CW-1:0]][cand_c[2'(d)][CW-1:0]]
                && !vis_q[cand_r[2'(d)][CW-1:0]][cand_c[2'(d)][CW-1:0]];
        end
        // Walk from lowest priority up so the highest-priority hit wins.
        sel_ok = 1'b0;
        sel_r  = '0;
        sel_c  = '0;
        for (int d = 3; d >= 0; d--) begin
            if (cand_ok[2'(d)]) begin
                sel_ok = 1'b1;
                sel_r  = cand_r[2'(d)][CW-1:0];
                sel_c  = cand_c[2'(d)][CW-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        maze_d        = maze_q;
        vis_d         = vis_q;
        idx_d         = idx_q;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        out_row_d     = '0;
        out_col_d     = '0;
        no_path_d     = 1'b0;
        stk_clear     = 1'b0;
        stk_push      = 1'b0;
        stk_pop       = 1'b0;
        stk_push_data = {sel_r, sel_c};
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    maze_d[0] = maze;
                    row_cnt_d = CW'(1);
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    maze_d[row_cnt_q] = maze;
                    if (row_cnt_q == CW'(N - 1)) state_d = S_INIT;
                    else                         row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            S_INIT: begin
                if (!maze_q[0][N-1] || !maze_q[N-1][0]) begin
                    no_path_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    stk_clear          = 1'b1;
                    stk_push           = 1'b1;
                    stk_push_data      = {CW'(0), CW'(N - 1)};
                    vis_d              = '0;
                    vis_d[0][N-1]      = 1'b1;
                    state_d            = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (stk_empty) begin
                    no_path_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (top_row == CW'(N - 1) && top_col == '0) begin
                    idx_d   = '0;
                    state_d = S_OUTPUT;
                end else if (sel_ok) begin
                    stk_push            = 1'b1;
                    vis_d[sel_r][sel_c] = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                    if (stk_sp == PW'(1)) begin
                        no_path_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_OUTPUT: begin
                // Leave only once the last beat is on the outputs, so busy
                // covers the whole stream.
                if (out_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    out_valid_d            = 1'b1;
                    {out_row_d, out_col_d} = stk_rd;
                    out_last_d             = (PW'(idx_q) + 1'b1 == stk_sp);
                    idx_d                  = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            maze_q      <= '0;
            vis_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            no_path_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            maze_q      <= maze_d;
            vis_q       <= vis_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            no_path_q   <= no_path_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign no_path   = no_path_q;

endmodule

// File: tb/tb_maze_path_finder.sv
module tb_maze_path_finder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv8, busy8, ov8, ol8, np8;
    logic [7:0] mz8;
    logic [2:0] or8, oc8;
    logic       iv4, busy4, ov4, ol4, np4;
    logic [3:0] mz4;
    logic [1:0] or4, oc4;

    maze_path_finder #(.N(8), .FOUR_DIR(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .maze(mz8), .busy(busy8),
        .out_valid(ov8), .out_row(or8), .out_col(oc8), .out_last(ol8), .no_path(np8)
    );

    maze_path_finder #(.N(4), .FOUR_DIR(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .maze(mz4), .busy(busy4),
        .out_valid(ov4), .out_row(or4), .out_col(oc4), .out_last(ol4), .no_path(np4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_r[$], exp_c[$], got_r[$], got_c[$];
    bit got_l[$];
    bit col_done, col_np;

    localparam logic [63:0] M_OPEN   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M_BACK   = 64'h0101_0101_81FF_8080;
    localparam logic [63:0] M_NOSTRT = 64'hFFFF_FFFF_FFFF_FF7F;
    localparam logic [15:0] M_UP4    = 16'h1DF8;

    // Called at a negedge; returns at the negedge after the last beat.
    task automatic load8(input logic [63:0] m, input int gap);
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < gap; g++) begin
                iv8 = 1'b0; mz8 = 8'h00; @(negedge clk);
            end
            iv8 = 1'b1; mz8 = m[r*8 +: 8]; @(negedge clk);
        end
        iv8 = 1'b0; mz8 = 8'h00;
    endtask

    task automatic load4(input logic [15:0] m);
        for (int r = 0; r < 4; r++) begin
            iv4 = 1'b1; mz4 = m[r*4 +: 4]; @(negedge clk);
        end
        iv4 = 1'b0; mz4 = 4'h0;
    endtask

    // Records path beats until out_last or the cycle budget runs out.
    task automatic collect(input bit sel4);
        int cyc;
        cyc = 0;
        col_done = 1'b0;
        col_np   = 1'b0;
        got_r.delete(); got_c.delete(); got_l.delete();
        while (!col_done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (sel4 ? np4 : np8) col_np = 1'b1;
            if (sel4 ? ov4 : ov8) begin
                got_r.push_back(sel4 ? int'(or4) : int'(or8));
                got_c.push_back(sel4 ? int'(oc4) : int'(oc8));
                got_l.push_back(sel4 ? ol4 : ol8);
                if (sel4 ? ol4 : ol8) col_done = 1'b1;
            end
        end
    endtask

    task automatic exp_open();
        exp_r.delete(); exp_c.delete();
        for (int r = 0; r < 8; r++) begin exp_r.push_back(r); exp_c.push_back(7); end
        for (int c = 6; c >= 0; c--) begin exp_r.push_back(7); exp_c.push_back(c); end
    endtask

    task automatic exp_back();
        exp_r.delete(); exp_c.delete();
        exp_r.push_back(0); exp_c.push_back(7);
        exp_r.push_back(1); exp_c.push_back(7);
        for (int c = 7; c >= 0; c--) begin exp_r.push_back(2); exp_c.push_back(c); end
        for (int r = 3; r < 8; r++) begin exp_r.push_back(r); exp_c.push_back(0); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv8 = 1'b0; mz8 = '0; iv4 = 1'b0; mz4 = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy8, ov8, ol8, np8, or8, oc8} !== 10'd0) begin
            n_bad++; $display("FAIL reset_out8: got %b want 0", {busy8, ov8, ol8, np8, or8, oc8});
        end
        n_cmp++;
        if ({busy4, ov4, ol4, np4, or4, oc4} !== 8'd0) begin
            n_bad++; $display("FAIL reset_out4: got %b want 0", {busy4, ov4, ol4, np4, or4, oc4});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy8); end
    endtask

    task automatic test_all_open();
        n_cmp++;
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL open_busy_pre: got %b want 0", busy8); end
        load8(M_OPEN, 0);
        n_cmp++;
        if (busy8 !== 1'b1) begin n_bad++; $display("FAIL open_busy: got %b want 1", busy8); end
        collect(1'b0);
        exp_open();
        n_cmp++;
        if (!col_done) begin n_bad++; $display("FAIL open_timeout: got no out_last want out_last"); end
        n_cmp++;
        if (col_np !== 1'b0) begin n_bad++; $display("FAIL open_no_path: got 1 want 0"); end
        n_cmp++;
        if (got_r.size() !== exp_r.size()) begin
            n_bad++; $display("FAIL open_len: got %0d want %0d", got_r.size(), exp_r.size());
        end
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
            n_cmp++;
            if (got_r[i] !== exp_r[i] || got_c[i] !== exp_c[i] || got_l[i] !== (i == exp_r.size() - 1)) begin
                n_bad++;
                $display("FAIL open_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         i, got_r[i], got_c[i], got_l[i], exp_r[i], exp_c[i], i == exp_r.size() - 1);
            end
        end
    endtask

    // Starts straight after test_all_open: reload in the first IDLE cycle.
    task automatic test_back_to_back();
        @(negedge clk);
        n_cmp++;
        if ({ov8, busy8} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_idle: got ov=%b busy=%b want 0 0", ov8, busy8);
        end
        load8(M_BACK, 0);
        collect(1'b0);
        exp_back();
        n_cmp++;
        if (!col_done || col_np) begin
            n_bad++; $display("FAIL b2b_done: got done=%0d np=%0d want 1 0", col_done, col_np);
        end
        n_cmp++;
        if (got_r.size() !== exp_r.size()) begin
            n_bad++; $display("FAIL b2b_len: got %0d want %0d", got_r.size(), exp_r.size());
        end
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
            n_cmp++;
            if (got_r[i] !== exp_r[i] || got_c[i] !== exp_c[i] || got_l[i] !== (i == exp_r.size() - 1)) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         i, got_r[i], got_c[i], got_l[i], exp_r[i], exp_c[i], i == exp_r.size() - 1);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_gaps();
        load8(M_BACK, 2);
        collect(1'b0);
        exp_back();
        n_cmp++;
        if (!col_done || col_np) begin
            n_bad++; $display("FAIL gap_done: got done=%0d np=%0d want 1 0", col_done, col_np);
        end
        n_cmp++;
        if (got_r.size() !== exp_r.size()) begin
            n_bad++; $display("FAIL gap_len: got %0d want %0d", got_r.size(), exp_r.size());
        end
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
            n_cmp++;
            if (got_r[i] !== exp_r[i] || got_c[i] !== exp_c[i] || got_l[i] !== (i == exp_r.size() - 1)) begin
                n_bad++;
                $display("FAIL gap_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         i, got_r[i], got_c[i], got_l[i], exp_r[i], exp_c[i], i == exp_r.size() - 1);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_no_path();
        bit ov_seen;
        load8(M_NOSTRT, 0);
        n_cmp++;
        if (np8 !== 1'b0) begin n_bad++; $display("FAIL nopath_early: got %b want 0", np8); end
        @(negedge clk);
        n_cmp++;
        if (np8 !== 1'b1) begin n_bad++; $display("FAIL nopath_pulse: got %b want 1", np8); end
        @(negedge clk);
        n_cmp++;
        if ({np8, busy8} !== 2'b00) begin
            n_bad++; $display("FAIL nopath_end: got np=%b busy=%b want 0 0", np8, busy8);
        end
        ov_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ov8) ov_seen = 1'b1;
        end
        n_cmp++;
        if (ov_seen !== 1'b0) begin n_bad++; $display("FAIL nopath_out_valid: got 1 want 0"); end
    endtask

    task automatic test_four_dir();
        bit went_up;
        load4(M_UP4);
        collect(1'b1);
        exp_r = '{0, 1, 2, 2, 1, 1, 1, 2, 3};
        exp_c = '{3, 3, 3, 2, 2, 1, 0, 0, 0};
        n_cmp++;
        if (!col_done || col_np) begin
            n_bad++; $display("FAIL four_done: got done=%0d np=%0d want 1 0", col_done, col_np);
        end
        n_cmp++;
        if (got_r.size() !== exp_r.size()) begin
            n_bad++; $display("FAIL four_len: got %0d want %0d", got_r.size(), exp_r.size());
        end
        went_up = 1'b0;
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
            if (i > 0 && got_r[i] < got_r[i-1]) went_up = 1'b1;
            n_cmp++;
            if (got_r[i] !== exp_r[i] || got_c[i] !== exp_c[i] || got_l[i] !== (i == exp_r.size() - 1)) begin
                n_bad++;
                $display("FAIL four_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         i, got_r[i], got_c[i], got_l[i], exp_r[i], exp_c[i], i == exp_r.size() - 1);
            end
        end
        n_cmp++;
        if (went_up !== 1'b1) begin n_bad++; $display("FAIL four_up_move: got 0 want 1"); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_search();
        bit act_seen;
        load8(M_OPEN, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy8 !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 1", busy8); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, ov8, ol8, np8, or8, oc8} !== 10'd0) begin
            n_bad++; $display("FAIL rst_mid_out: got %b want 0", {busy8, ov8, ol8, np8, or8, oc8});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        act_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ov8 || busy8 || np8) act_seen = 1'b1;
        end
        n_cmp++;
        if (act_seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_residue: got activity want none"); end
        load8(M_OPEN, 0);
        collect(1'b0);
        exp_open();
        n_cmp++;
        if (!col_done || col_np) begin
            n_bad++; $display("FAIL rst_reload_done: got done=%0d np=%0d want 1 0", col_done, col_np);
        end
        n_cmp++;
        if (got_r.size() !== exp_r.size()) begin
            n_bad++; $display("FAIL rst_reload_len: got %0d want %0d", got_r.size(), exp_r.size());
        end
        for (int i = 0; i < exp_r.size() && i < got_r.size(); i++) begin
            n_cmp++;
            if (got_r[i] !== exp_r[i] || got_c[i] !== exp_c[i] || got_l[i] !== (i == exp_r.size() - 1)) begin
                n_bad++;
                $display("FAIL rst_reload_beat%0d: got (%0d,%0d,last=%0d) want (%0d,%0d,last=%0d)",
                         i, got_r[i], got_c[i], got_l[i], exp_r[i], exp_c[i], i == exp_r.size() - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_open();
        test_back_to_back();
        test_gaps();
        test_no_path();
        test_four_dir();
        test_reset_mid_search();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1ms want finish");
        $fatal(1, "watchdog");
    end

endmodule
